// File: rtl/rv_pkg.sv
// rv_pkg: shared widths and writeback request type for the register file write scheduler
// Ports: none (package)
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = $clog2(NREG);
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with one-hot grant
// Ports: clk, rst_n (async active-low), req[1:0] requests, gnt[1:0] one-hot grant (0 in reset)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr_last;
  // On a tie the source that did not win last time is granted; rr_last resets to 1 so src0 wins first.
  always_comb gnt = !rst_n ? 2'b00 : (&req) ? (rr_last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last <= 1'b1;
    else if (|gnt) rr_last <= gnt[1];
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: arbitrates ALU/LSU writebacks onto the register file write port and tracks pending writes
// Ports: clk_i, rst_ni (async active-low); src0_* ALU request/ready; src1_* LSU request/ready;
//        iss_valid_i/iss_rd_i mark a pending writer; rs1_i/rs2_i -> hazard1_o/hazard2_o;
//        dataW_o/rsW_o/RegWEn_o drive the register file write port one cycle after a transfer
module regfile_wb_sched
  import rv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              src0_valid_i,
  input  logic [REG_AW-1:0] src0_rd_i,
  input  logic [XLEN-1:0]   src0_data_i,
  output logic              src0_ready_o,
  input  logic              src1_valid_i,
  input  logic [REG_AW-1:0] src1_rd_i,
  input  logic [XLEN-1:0]   src1_data_i,
  output logic              src1_ready_o,
  input  logic              iss_valid_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic [XLEN-1:0]   dataW_o,
  output logic [REG_AW-1:0] rsW_o,
  output logic              RegWEn_o
);
  wb_req_t req0, req1;
  logic [1:0] gnt;
  logic xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy, set_v, clr_v;
  assign req0 = {src0_valid_i, src0_rd_i, src0_data_i};
  assign req1 = {src1_valid_i, src1_rd_i, src1_data_i};
  rr_arb2 u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   ({req1.valid, req0.valid}),
    .gnt   (gnt)
  );
  assign src0_ready_o = gnt[0];
  assign src1_ready_o = gnt[1];
  assign xfer = |gnt;
  assign sel_rd = gnt[1] ? req1.rd : req0.rd;
  assign sel_data = gnt[1] ? req1.data : req0.data;
  // x0 is never marked busy; set is OR'd after clear so a same-cycle reissue keeps the bit.
  assign set_v = iss_valid_i ? ((NREG'(1) << iss_rd_i) & ~NREG'(1)) : '0;
  assign clr_v = RegWEn_o ? (NREG'(1) << rsW_o) : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      RegWEn_o <= 1'b0;
      rsW_o <= '0;
      dataW_o <= '0;
      busy <= '0;
    end else begin
      RegWEn_o <= xfer && sel_rd != '0;
      if (xfer) begin
        rsW_o <= sel_rd;
        dataW_o <= sel_data;
      end
      busy <= (busy & ~clr_v) | set_v;
    end
  assign hazard1_o = busy[rs1_i];
  assign hazard2_o = busy[rs2_i];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_v = 1'b0, s1_v = 1'b0, iss_v = 1'b0;
  logic [4:0] s0_rd = '0, s1_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] s0_d = '0, s1_d = '0;
  logic s0_rdy, s1_rdy, hz1, hz2, wen;
  logic [4:0] rsw;
  logic [31:0] dw;
  int vectors = 0, errs = 0;

  regfile_wb_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .src0_valid_i(s0_v), .src0_rd_i(s0_rd), .src0_data_i(s0_d), .src0_ready_o(s0_rdy),
    .src1_valid_i(s1_v), .src1_rd_i(s1_rd), .src1_data_i(s1_d), .src1_ready_o(s1_rdy),
    .iss_valid_i(iss_v), .iss_rd_i(iss_rd), .rs1_i(rs1), .rs2_i(rs2),
    .hazard1_o(hz1), .hazard2_o(hz2),
    .dataW_o(dw), .rsW_o(rsw), .RegWEn_o(wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    s0_v = 1'b1; s0_rd = 5'd5; s0_d = 32'hAAAA;
    repeat (3) step();
    chk("rst_wen", 32'(wen), 0);
    chk("rst_rdy0", 32'(s0_rdy), 0);
    chk("rst_rdy1", 32'(s1_rdy), 0);
    chk("rst_hz1", 32'(hz1), 0);
    chk("rst_hz2", 32'(hz2), 0);
    rst_n = 1'b1;
    s1_v = 1'b1; s1_rd = 5'd6; s1_d = 32'h5555;
    #1;
    chk("tie_rdy0", 32'(s0_rdy), 1);
    chk("tie_rdy1", 32'(s1_rdy), 0);
    step();
    chk("w5_wen", 32'(wen), 1);
    chk("w5_rsw", 32'(rsw), 5);
    chk("w5_data", dw, 32'hAAAA);
    chk("tie2_rdy0", 32'(s0_rdy), 0);
    chk("tie2_rdy1", 32'(s1_rdy), 1);
    step();
    chk("w6_wen", 32'(wen), 1);
    chk("w6_rsw", 32'(rsw), 6);
    chk("w6_data", dw, 32'h5555);
    s0_v = 1'b0; s1_v = 1'b0;
    step();
    chk("idle_wen", 32'(wen), 0);
    chk("idle_rsw_hold", 32'(rsw), 6);
    chk("idle_data_hold", dw, 32'h5555);
    iss_v = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    #1 chk("sb_pre_hz1", 32'(hz1), 0);
    step();
    iss_v = 1'b0;
    chk("sb_set_hz1", 32'(hz1), 1);
    s1_v = 1'b1; s1_rd = 5'd7; s1_d = 32'h77;
    #1 chk("sb_rdy1", 32'(s1_rdy), 1);
    step();
    s1_v = 1'b0;
    chk("sb_w7_wen", 32'(wen), 1);
    chk("sb_w7_rsw", 32'(rsw), 7);
    chk("sb_w7_hz1", 32'(hz1), 1);
    step();
    chk("sb_clr_hz1", 32'(hz1), 0);
    chk("sb_clr_wen", 32'(wen), 0);
    iss_v = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
    step();
    iss_v = 1'b0;
    s0_v = 1'b1; s0_rd = 5'd9; s0_d = 32'h99;
    step();
    s0_v = 1'b0;
    chk("col_wen", 32'(wen), 1);
    chk("col_rsw", 32'(rsw), 9);
    chk("col_hz2_before", 32'(hz2), 1);
    iss_v = 1'b1; iss_rd = 5'd9;
    step();
    iss_v = 1'b0;
    chk("col_hz2_kept", 32'(hz2), 1);
    chk("col_wen_off", 32'(wen), 0);
    s1_v = 1'b1; s1_rd = 5'd9; s1_d = 32'h999;
    step();
    s1_v = 1'b0;
    chk("col_rewrite_wen", 32'(wen), 1);
    step();
    chk("col_hz2_clr", 32'(hz2), 0);
    s0_v = 1'b1; s0_rd = 5'd0; s0_d = 32'hFFFF_FFFF;
    iss_v = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #1 chk("x0_rdy0", 32'(s0_rdy), 1);
    step();
    s0_v = 1'b0; iss_v = 1'b0;
    chk("x0_wen", 32'(wen), 0);
    chk("x0_hz1", 32'(hz1), 0);
    s0_v = 1'b1; s0_rd = 5'd1; s1_v = 1'b1; s1_rd = 5'd2;
    #1;
    chk("x0_rr_rdy0", 32'(s0_rdy), 0);
    chk("x0_rr_rdy1", 32'(s1_rdy), 1);
    s0_v = 1'b0; s1_v = 1'b0;
    iss_v = 1'b1; iss_rd = 5'd12; rs1 = 5'd12;
    step();
    iss_v = 1'b0;
    s0_v = 1'b1; s0_rd = 5'd13; s0_d = 32'hD;
    chk("ar_hz1_set", 32'(hz1), 1);
    step();
    chk("ar_wen_pre", 32'(wen), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_wen", 32'(wen), 0);
    chk("ar_rsw", 32'(rsw), 0);
    chk("ar_hz1", 32'(hz1), 0);
    chk("ar_rdy0", 32'(s0_rdy), 0);
    @(negedge clk);
    s0_v = 1'b0;
    rst_n = 1'b1;
    step();
    chk("ar_no_pulse", 32'(wen), 0);
    s0_v = 1'b1; s1_v = 1'b1;
    #1 chk("ar_rr_reset", 32'(s0_rdy), 1);
    s0_v = 1'b0; s1_v = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
